// File: rtl/band_sweep_gen.sv
// ---------------------------------------------------------------------------------------------
// band_sweep_gen
//
// Purpose:
//   Turns a band code (1..NUM_BANDS) into the full run of values covered by that band and
//   streams them out one per accepted beat. This is the inverse of a counter-to-band decoder
//   and is meant to drive stimulus into band-decoded counters.
//   Band b covers lo = (b-1)*BAND_SIZE+1 .. hi = b*BAND_SIZE (defaults: 1->1..3, 2->4..6,
//   3->7..9).
//
// Optional feature (compile-time macro BAND_SWEEP_DIR_EN):
//   When defined, port dir_i exists and is sampled with each accepted request:
//   0 sweeps lo..hi, 1 sweeps hi..lo. When undefined every sweep is ascending.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   band_valid_i  band_code_i is valid
//   band_ready_o  block can accept a band request (registered)
//   band_code_i   requested band, W bits
//   dir_i         sweep direction (only with BAND_SWEEP_DIR_EN)
//   y_valid_o     y_o holds a valid sweep value (registered)
//   y_ready_i     downstream accepts y_o this cycle
//   y_o           current sweep value, W bits (registered)
//   y_last_o      y_o is the final value of the sweep (registered, qualified by y_valid_o)
//   err_o         one-cycle pulse after an illegal band code was accepted (registered)
// ---------------------------------------------------------------------------------------------
module band_sweep_gen #(
    parameter int unsigned W         = 4,
    parameter int unsigned BAND_SIZE = 3,
    parameter int unsigned NUM_BANDS = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         band_valid_i,
    output logic         band_ready_o,
    input  logic [W-1:0] band_code_i,
`ifdef BAND_SWEEP_DIR_EN
    input  logic         dir_i,
`endif
    output logic         y_valid_o,
    input  logic         y_ready_i,
    output logic [W-1:0] y_o,
    output logic         y_last_o,
    output logic         err_o
);

    // -----------------------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------------------------
    if (BAND_SIZE < 1) begin : g_bad_band_size
        $error("band_sweep_gen: BAND_SIZE must be >= 1");
    end

    if (NUM_BANDS < 1) begin : g_bad_num_bands
        $error("band_sweep_gen: NUM_BANDS must be >= 1");
    end

    // The highest value hi = NUM_BANDS*BAND_SIZE must fit in W bits.
    if ((NUM_BANDS * BAND_SIZE) > ((2 ** W) - 1)) begin : g_bad_range
        $error("band_sweep_gen: NUM_BANDS*BAND_SIZE exceeds 2**W-1");
    end

    localparam logic [W-1:0] BandSizeW = W'(BAND_SIZE);
    localparam logic [W-1:0] NumBandsW = W'(NUM_BANDS);

    // -----------------------------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------------------------
    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } state_e;

    state_e        state_q, state_d;

    logic          band_ready_q, band_ready_d;
    logic          y_valid_q, y_valid_d;
    logic [W-1:0]  y_q, y_d;
    logic          y_last_q, y_last_d;
    logic          err_q, err_d;
    logic [W-1:0]  end_q, end_d;      // final value of the current sweep
    logic          dir_q, dir_d;      // 1: descending sweep

    logic          req_dir;
    logic          req_acc;
    logic          beat_acc;
    logic          code_legal;
    logic          at_end;
    logic [W-1:0]  code_m1;
    logic [W-1:0]  band_lo;
    logic [W-1:0]  band_hi;
    logic [W-1:0]  y_step;

`ifdef BAND_SWEEP_DIR_EN
    assign req_dir = dir_i;
`else
    assign req_dir = 1'b0;
`endif

    // -----------------------------------------------------------------------------------------
    // Request decode and datapath helpers
    // -----------------------------------------------------------------------------------------
    assign req_acc    = band_valid_i & band_ready_q;
    assign beat_acc   = y_valid_q & y_ready_i;
    assign code_legal = (band_code_i != '0) && (band_code_i <= NumBandsW);

    // Only used when code_legal holds, so the W-bit products cannot overflow.
    assign code_m1 = band_code_i - W'(1);
    assign band_lo = (code_m1 * BandSizeW) + W'(1);
    assign band_hi = band_code_i * BandSizeW;

    assign at_end = (y_q == end_q);
    assign y_step = dir_q ? (y_q - W'(1)) : (y_q + W'(1));

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_acc && code_legal) begin
                    state_d = StSweep;
                end
            end
            StSweep: begin
                if (beat_acc && at_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs and sweep context)
    // -----------------------------------------------------------------------------------------
    always_comb begin
        band_ready_d = 1'b0;
        y_valid_d    = y_valid_q;
        y_d          = y_q;
        y_last_d     = y_last_q;
        err_d        = 1'b0;       // err is always a single-cycle pulse
        end_d        = end_q;
        dir_d        = dir_q;

        unique case (state_q)
            StIdle: begin
                band_ready_d = 1'b1;
                y_valid_d    = 1'b0;
                y_last_d     = 1'b0;
                if (req_acc) begin
                    if (code_legal) begin
                        band_ready_d = 1'b0;
                        y_valid_d    = 1'b1;
                        dir_d        = req_dir;
                        y_d          = req_dir ? band_hi : band_lo;
                        end_d        = req_dir ? band_lo : band_hi;
                        // Single-value bands are last on their first beat.
                        y_last_d     = (band_lo == band_hi);
                    end else begin
                        // Illegal code: stay ready, leave y untouched.
                        err_d = 1'b1;
                    end
                end
            end
            StSweep: begin
                if (beat_acc) begin
                    if (at_end) begin
                        // Ready goes high on the first idle cycle so the next
                        // request can be taken immediately.
                        y_valid_d    = 1'b0;
                        y_last_d     = 1'b0;
                        band_ready_d = 1'b1;
                    end else begin
                        y_d      = y_step;
                        y_last_d = (y_step == end_q);
                    end
                end
            end
            default: begin
                y_valid_d = 1'b0;
                y_last_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Output and sweep-context registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            band_ready_q <= 1'b0;
            y_valid_q    <= 1'b0;
            y_q          <= '0;
            y_last_q     <= 1'b0;
            err_q        <= 1'b0;
            end_q        <= '0;
            dir_q        <= 1'b0;
        end else begin
            band_ready_q <= band_ready_d;
            y_valid_q    <= y_valid_d;
            y_q          <= y_d;
            y_last_q     <= y_last_d;
            err_q        <= err_d;
            end_q        <= end_d;
            dir_q        <= dir_d;
        end
    end

    assign band_ready_o = band_ready_q;
    assign y_valid_o    = y_valid_q;
    assign y_o          = y_q;
    assign y_last_o     = y_last_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_band_sweep_gen.sv
// ---------------------------------------------------------------------------------------------
// tb_band_sweep_gen
//
// Self-checking bench for band_sweep_gen with default parameters (W=4, BAND_SIZE=3,
// NUM_BANDS=3). Expected sweeps are built as queues of values from the band mapping; outputs
// are sampled on the falling clock edge and inputs are driven right after sampling.
// ---------------------------------------------------------------------------------------------
module tb_band_sweep_gen;

    localparam int W  = 4;
    localparam int BS = 3;
    localparam int NB = 3;

    logic         clk;
    logic         rst_n;
    logic         band_valid;
    logic         band_ready;
    logic [W-1:0] band_code;
    logic         dir;
    logic         y_valid;
    logic         y_ready;
    logic [W-1:0] y;
    logic         y_last;
    logic         err;

    int errs   = 0;
    int checks = 0;
    int m_y    = 0;   // last value shown on y

    band_sweep_gen #(
        .W         (W),
        .BAND_SIZE (BS),
        .NUM_BANDS (NB)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .band_valid_i (band_valid),
        .band_ready_o (band_ready),
        .band_code_i  (band_code),
`ifdef BAND_SWEEP_DIR_EN
        .dir_i        (dir),
`endif
        .y_valid_o    (y_valid),
        .y_ready_i    (y_ready),
        .y_o          (y),
        .y_last_o     (y_last),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, band_ready, 0);
        chk({tag, "_valid"}, y_valid, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_last"}, y_last, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Request a legal band and follow the whole sweep. rnd selects random y_ready,
    // otherwise bit k of stall holds y_ready low on the k-th output cycle.
    task automatic sweep(input int code, input bit d, input bit rnd, input logic [31:0] stall);
        int q[$];
        int lo;
        int hi;
        int idx;
        int k;
        bit r;
        lo = (code - 1) * BS + 1;
        hi = code * BS;
        for (int v = lo; v <= hi; v++) begin
            if (d) q.push_front(v);
            else   q.push_back(v);
        end
        chk("req_ready", band_ready, 1);
        band_valid = 1'b1;
        band_code  = W'(code);
        dir        = d;
        y_ready    = 1'b0;
        @(negedge clk);
        band_valid = 1'b0;
        band_code  = W'($urandom);
        idx = 0;
        k   = 0;
        while (idx < q.size() && k < 64) begin
            chk("y_valid", y_valid, 1);
            chk("y", y, q[idx]);
            chk("y_last", y_last, 32'(idx == q.size() - 1));
            chk("busy_ready", band_ready, 0);
            chk("busy_err", err, 0);
            if (rnd) r = ($urandom_range(0, 3) != 0);
            else     r = (k < 32) ? !stall[k] : 1'b1;
            y_ready = r;
            dir     = 1'($urandom);   // must not affect a running sweep
            @(negedge clk);
            if (r) idx++;
            k++;
        end
        chk("sweep_done", idx, q.size());
        y_ready = 1'($urandom);
        chk("end_valid", y_valid, 0);
        chk("end_last", y_last, 0);
        chk("end_ready", band_ready, 1);
        m_y = q[q.size() - 1];
    endtask

    task automatic illegal(input int code);
        chk("ill_req_ready", band_ready, 1);
        band_valid = 1'b1;
        band_code  = W'(code);
        @(negedge clk);
        band_valid = 1'b0;
        band_code  = W'($urandom);
        chk("ill_err", err, 1);
        chk("ill_valid", y_valid, 0);
        chk("ill_ready", band_ready, 1);
        chk("ill_y", y, m_y);
    endtask

    initial begin
        int code;
        bit d;
        rst_n      = 1'b0;
        band_valid = 1'b0;
        band_code  = '0;
        dir        = 1'b0;
        y_ready    = 1'b0;

        // Reset held for 3 clocks, then released.
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("rst");
        end
        rst_n = 1'b1;
        #1 chk("rel_ready_low", band_ready, 0);
        @(negedge clk);
        chk("rel_ready_high", band_ready, 1);
        chk("rel_valid", y_valid, 0);

        // Band 2 with y_ready held high: 4,5,6.
        sweep(2, 1'b0, 1'b0, 32'h0);

        // Band 3 with y_ready low for 2 cycles on the second beat.
        sweep(3, 1'b0, 1'b0, 32'h6);

        // Illegal codes back to back.
        illegal(0);
        illegal(NB + 1);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_clear_ready", band_ready, 1);
        chk("err_clear_valid", y_valid, 0);

        // Reset in the middle of a band 1 sweep.
        chk("mid_req_ready", band_ready, 1);
        band_valid = 1'b1;
        band_code  = 4'd1;
        dir        = 1'b0;
        y_ready    = 1'b1;
        @(negedge clk);
        band_valid = 1'b0;
        chk("mid_y1", y, 1);
        @(negedge clk);
        chk("mid_y2", y, 2);
        @(negedge clk);
        chk("mid_y3", y, 3);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rel_ready_low", band_ready, 0);
        @(negedge clk);
        chk("mid_rel_ready", band_ready, 1);
        chk("mid_rel_valid", y_valid, 0);
        y_ready = 1'b0;
        m_y     = 0;
        sweep(3, 1'b0, 1'b0, 32'h0);

`ifdef BAND_SWEEP_DIR_EN
        // Descending band 2: 6,5,4 with dir toggling during the sweep.
        sweep(2, 1'b1, 1'b0, 32'h0);
`endif

        // Random mix of legal and illegal requests with random backpressure.
        for (int i = 0; i < 20; i++) begin
            code = $urandom_range(0, NB + 2);
`ifdef BAND_SWEEP_DIR_EN
            d = 1'($urandom);
`else
            d = 1'b0;
`endif
            if (code >= 1 && code <= NB) begin
                sweep(code, d, 1'b1, 32'h0);
            end else begin
                illegal(code);
                @(negedge clk);
                chk("rnd_err_clear", err, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
